jzjpcc_writeback: RTL
=====================

// Module: jzjpcc_writeback
// PURPOSE
//  Writeback stage of the pipelined core: final pipeline register ahead of the register file.
//  Accepts retiring instructions from the memory stage and selects ALU result, PC+4 or extracted load data.
//  Drives the regfile write port and exposes forwarding/pending-load info to the hazard unit.
//  Posedge-registered outputs are written by the regfile on the following negedge of the same cycle.
// PARAMETERS
//  XLEN        32  datapath width (only 32 supported)
//  CNT_WIDTH   64  retire counter width (used only with JZJPCC_WB_RETIRE_COUNT_EN)
// PORTS
//  clock          in   1     core clock; all state updates on posedge
//  reset          in   1     synchronous, active-low reset
//  inValid        in   1     memory stage presents an instruction
//  inReady        out  1     stage can accept this cycle
//  inRdAddr       in   5     destination register
//  inWriteEn      in   1     instruction writes rd
//  inSrc          in   2     wb_src_t: WB_ALU / WB_LOAD / WB_PC4
//  inAluResult    in   32    ALU result; for loads, the byte address (bits [1:0] = offset)
//  inPcPlus4      in   32    link value for JAL/JALR
//  inFunct3       in   3     load type (LB/LH/LW/LBU/LHU)
//  dmemValid      in   1     load data returned this cycle
//  dmemData       in   32    raw aligned word from data memory
//  rdAddr         out  5     regfile write address
//  rd             out  32    regfile write data
//  rdWriteEn      out  1     regfile write enable (one cycle per retired write)
//  pendingLoad    out  1     a load is waiting for data
//  pendingRdAddr  out  5     destination of the pending load
//  loadFault      out  1     one-cycle pulse: misaligned or illegal-funct3 load
//  retireCount    out  CNT_WIDTH  instructions retired (only with JZJPCC_WB_RETIRE_COUNT_EN)
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE; rdAddr=0, rd=0, rdWriteEn=0, pendingLoad=0,
//   pendingRdAddr=0, loadFault=0, retireCount=0; in-flight load discarded.
//  FSM: IDLE, WAIT_LOAD. inReady = (state==IDLE).
//  IDLE, inValid&&inSrc!=WB_LOAD: next cycle rdWriteEn=inWriteEn&&(inRdAddr!=0),
//   rd = ALU result or PC+4; back-to-back acceptance every cycle (latency 1).
//  IDLE, inValid&&inSrc==WB_LOAD: latch rdAddr/writeEn/funct3/offset; -> WAIT_LOAD;
//   pendingLoad=1, pendingRdAddr=inRdAddr from next cycle; rdWriteEn=0 that cycle.
//  WAIT_LOAD: inReady=0; dmemValid ignored until here. On dmemValid: next cycle
//   rd=extracted data, rdWriteEn per latched writeEn (x0 suppressed), pendingLoad=0, -> IDLE.
//  dmemValid in IDLE is ignored; earliest legal return is the cycle after acceptance.
//  Extraction: LB/LBU byte at offset, sign/zero-extended; LH/LHU halfword at offset[1],
//   sign/zero-extended; LW full word.
//  Fault: LH/LHU with offset[0]=1, LW with offset!=0, or funct3 in {011,110,111}:
//   detected at acceptance; no WAIT_LOAD, rdWriteEn=0, loadFault=1 next cycle only.
//  rdWriteEn is never high for two cycles from one instruction; rdAddr==0 never written.
//  Reset asserted during WAIT_LOAD: return to IDLE; late dmemValid is then ignored.
// CONFIGURATION
//  JZJPCC_WB_RETIRE_COUNT_EN defined: retireCount increments by 1 in the cycle an instruction
//   completes (non-load accepted, load data registered, or fault), wraps at 2^CNT_WIDTH.
//  Undefined: retireCount port and counter absent.
// STRUCTURE
//  jzjpcc_pkg: wb_src_t enum, funct3 load constants (LB=000 LH=001 LW=010 LBU=100 LHU=101),
//   wb_state_t enum.
//  Sub-module jzjpcc_load_extract: combinational funct3/offset/word -> data + fault.
// TESTING
//  ALU op rd=5, aluResult=0x1234_5678 -> next cycle rdWriteEn=1, rdAddr=5, rd=0x1234_5678.
//  Three back-to-back ALU/PC4 ops -> inReady stays 1, three consecutive single-cycle writes.
//  LB offset=3, dmemData=0x80AB_CDEF, dmemValid 2 cycles later -> rd=0xFFFF_FF80,
//   pendingLoad high exactly 2 cycles; LBU same -> rd=0x0000_0080.
//  LHU offset=2, dmemData=0xBEEF_0000 -> rd=0x0000_BEEF; LH same -> rd=0xFFFF_BEEF.
//  LW offset=1 -> loadFault one-cycle pulse, rdWriteEn=0, inReady stays 1.
//  Reset low during WAIT_LOAD, then dmemValid -> no write, state IDLE, pendingLoad=0;
//   ALU op to rd=0 -> rdWriteEn=0.

Source files
------------

// File: rtl/jzjpcc_pkg.sv
// Shared types and load-type encodings for the jzjpcc writeback stage.
package jzjpcc_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10
    } wb_src_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/jzjpcc_writeback_if.sv
// Memory-stage handshake, data-memory return and regfile/hazard outputs of the writeback stage.
interface jzjpcc_writeback_if;
    import jzjpcc_pkg::*;

    logic        inValid;
    logic        inReady;
    logic [4:0]  inRdAddr;
    logic        inWriteEn;
    wb_src_t     inSrc;
    logic [31:0] inAluResult;
    logic [31:0] inPcPlus4;
    logic [2:0]  inFunct3;
    logic        dmemValid;
    logic [31:0] dmemData;
    logic [4:0]  rdAddr;
    logic [31:0] rd;
    logic        rdWriteEn;
    logic        pendingLoad;
    logic [4:0]  pendingRdAddr;
    logic        loadFault;

    modport master (
        output inValid, inRdAddr, inWriteEn, inSrc, inAluResult, inPcPlus4, inFunct3,
               dmemValid, dmemData,
        input  inReady, rdAddr, rd, rdWriteEn, pendingLoad, pendingRdAddr, loadFault
    );

    modport slave (
        input  inValid, inRdAddr, inWriteEn, inSrc, inAluResult, inPcPlus4, inFunct3,
               dmemValid, dmemData,
        output inReady, rdAddr, rd, rdWriteEn, pendingLoad, pendingRdAddr, loadFault
    );

endinterface

// File: rtl/jzjpcc_load_extract.sv
// Combinational load data extraction: picks byte/halfword/word at the offset and extends it,
// flagging misaligned accesses and unsupported funct3 encodings.
module jzjpcc_load_extract
    import jzjpcc_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_word,
    output logic [31:0] o_data,
    output logic        o_fault
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = i_word[7:0];
        case (i_offset)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half  = i_offset[1] ? i_word[31:16] : i_word[15:0];

        o_data  = '0;
        o_fault = 1'b0;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {24'b0, w_byte};
            F3_LH: begin
                o_data  = {{16{w_half[15]}}, w_half};
                o_fault = i_offset[0];
            end
            F3_LHU: begin
                o_data  = {16'b0, w_half};
                o_fault = i_offset[0];
            end
            F3_LW: begin
                o_data  = i_word;
                o_fault = (i_offset != 2'b00);
            end
            default: o_fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/jzjpcc_writeback.sv
// Writeback stage: final register ahead of the regfile, with a one-load-in-flight wait state.
// Optional retire counter enabled by defining JZJPCC_WB_RETIRE_COUNT_EN.
module jzjpcc_writeback
    import jzjpcc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    jzjpcc_writeback_if.slave    bus
`ifdef JZJPCC_WB_RETIRE_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] retireCount
`endif
);

    if (XLEN != 32 || CNT_WIDTH < 1) begin : g_param_check
        $error("jzjpcc_writeback: XLEN must be 32 and CNT_WIDTH positive");
    end

    wb_state_t        r_state;
    wb_state_t        w_nextState;
    logic             w_ready;
    logic             w_accept;
    logic             w_isLoad;
    logic             w_loadDone;
    logic             w_done;

    logic [4:0]       r_rdAddr;
    logic [XLEN-1:0]  r_rd;
    logic             r_rdWriteEn;
    logic             r_pendingLoad;
    logic [4:0]       r_pendingRdAddr;
    logic             r_loadFault;
    logic             r_ldWriteEn;
    logic [2:0]       r_ldFunct3;
    logic [1:0]       r_ldOffset;

    logic [2:0]       w_exFunct3;
    logic [1:0]       w_exOffset;
    logic [31:0]      w_exData;
    logic             w_exFault;

    // In IDLE the extractor only judges the incoming load for faults; in WAIT_LOAD it
    // extracts the returned word using the latched type and offset.
    assign w_exFunct3 = (r_state == ST_IDLE) ? bus.inFunct3 : r_ldFunct3;
    assign w_exOffset = (r_state == ST_IDLE) ? bus.inAluResult[1:0] : r_ldOffset;

    jzjpcc_load_extract u_extract (
        .i_funct3 (w_exFunct3),
        .i_offset (w_exOffset),
        .i_word   (bus.dmemData),
        .o_data   (w_exData),
        .o_fault  (w_exFault)
    );

    assign w_isLoad   = (bus.inSrc == WB_LOAD);
    assign w_accept   = bus.inValid && w_ready;
    assign w_loadDone = (r_state == ST_WAIT_LOAD) && bus.dmemValid;
    assign w_done     = (w_accept && (!w_isLoad || w_exFault)) || w_loadDone;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (bus.inValid && w_isLoad && !w_exFault) begin
                    w_nextState = ST_WAIT_LOAD;
                end
            end
            ST_WAIT_LOAD: begin
                if (bus.dmemValid) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rdAddr        <= '0;
            r_rd            <= '0;
            r_rdWriteEn     <= 1'b0;
            r_pendingLoad   <= 1'b0;
            r_pendingRdAddr <= '0;
            r_loadFault     <= 1'b0;
            r_ldWriteEn     <= 1'b0;
            r_ldFunct3      <= '0;
            r_ldOffset      <= '0;
        end else begin
            r_rdWriteEn <= 1'b0;
            r_loadFault <= 1'b0;
            if (w_accept) begin
                if (!w_isLoad) begin
                    r_rdAddr    <= bus.inRdAddr;
                    r_rd        <= (bus.inSrc == WB_PC4) ? bus.inPcPlus4 : bus.inAluResult;
                    r_rdWriteEn <= bus.inWriteEn && (bus.inRdAddr != 5'd0);
                end else if (w_exFault) begin
                    r_loadFault <= 1'b1;
                end else begin
                    r_pendingLoad   <= 1'b1;
                    r_pendingRdAddr <= bus.inRdAddr;
                    r_ldWriteEn     <= bus.inWriteEn;
                    r_ldFunct3      <= bus.inFunct3;
                    r_ldOffset      <= bus.inAluResult[1:0];
                end
            end else if (w_loadDone) begin
                r_rdAddr      <= r_pendingRdAddr;
                r_rd          <= w_exData;
                r_rdWriteEn   <= r_ldWriteEn && (r_pendingRdAddr != 5'd0);
                r_pendingLoad <= 1'b0;
            end
        end
    end

`ifdef JZJPCC_WB_RETIRE_COUNT_EN
    logic [CNT_WIDTH-1:0] r_retireCount;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_retireCount <= '0;
        end else if (w_done) begin
            r_retireCount <= r_retireCount + 1'b1;
        end
    end

    assign retireCount = r_retireCount;
`else
    logic w_doneUnused;
    assign w_doneUnused = w_done;
`endif

    assign bus.inReady       = w_ready;
    assign bus.rdAddr        = r_rdAddr;
    assign bus.rd            = r_rd;
    assign bus.rdWriteEn     = r_rdWriteEn;
    assign bus.pendingLoad   = r_pendingLoad;
    assign bus.pendingRdAddr = r_pendingRdAddr;
    assign bus.loadFault     = r_loadFault;

endmodule
